uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter (8N1, 9600 baud, 100 MHz clk) between NUM_REQ byte requesters, e.g. echo path, status reporter, debug dump.
- Round-robin arbitration with a valid/ready byte handshake per requester.
- Sequences tx_start, waits for tx_done, and has a watchdog so a hung transmitter cannot stall the arbiter.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters, with a tx_done watchdog.
// Define UART_ARB_TAG_EN to precede each payload byte with an ASCII tag '0'+grant_id.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int unsigned     WD_W      = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      GRANT_RST = 3'(NUM_REQ - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_TAG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [2:0]         grant_q, grant_d;
    logic               active_q;
    logic               timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]    wd_q, wd_d;

`ifdef UART_ARB_TAG_EN
    logic [7:0]         payload_q, payload_d;
    logic               tag_phase_q, tag_phase_d;
`endif

    logic               lo_hit, hi_hit;
    logic [2:0]         lo_id, hi_id;
    logic [NUM_REQ-1:0] lo_oh, hi_oh;
    logic [7:0]         lo_byte, hi_byte;
    logic               win_hit;
    logic [2:0]         win_id;
    logic [NUM_REQ-1:0] win_oh;
    logic [7:0]         win_byte;

    // Lowest valid index above the last grant wins, else lowest valid index overall.
    always_comb begin
        lo_hit  = 1'b0;
        hi_hit  = 1'b0;
        lo_id   = '0;
        hi_id   = '0;
        lo_oh   = '0;
        hi_oh   = '0;
        lo_byte = '0;
        hi_byte = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_hit    = 1'b1;
                lo_id     = 3'(i);
                lo_oh     = '0;
                lo_oh[i]  = 1'b1;
                lo_byte   = req_data[8*i +: 8];
                if (3'(i) > grant_q) begin
                    hi_hit    = 1'b1;
                    hi_id     = 3'(i);
                    hi_oh     = '0;
                    hi_oh[i]  = 1'b1;
                    hi_byte   = req_data[8*i +: 8];
                end
            end
        end
    end

    assign win_hit  = lo_hit;
    assign win_id   = hi_hit ? hi_id   : lo_id;
    assign win_oh   = hi_hit ? hi_oh   : lo_oh;
    assign win_byte = hi_hit ? hi_byte : lo_byte;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;
        wd_d          = wd_q;
`ifdef UART_ARB_TAG_EN
        payload_d     = payload_q;
        tag_phase_d   = tag_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_hit && !tx_busy) begin
                    grant_d     = win_id;
                    req_ready_d = win_oh;
`ifdef UART_ARB_TAG_EN
                    tx_data_d   = 8'h30 + 8'(win_id);
                    payload_d   = win_byte;
                    state_d     = S_TAG;
`else
                    tx_data_d   = win_byte;
                    state_d     = S_START;
`endif
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                wd_d       = '0;
                state_d    = S_WAIT_DONE;
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                tx_start_d  = 1'b1;
                wd_d        = '0;
                tag_phase_d = 1'b1;
                state_d     = S_WAIT_DONE;
            end
`endif
            S_WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                // tx_done wins over a coincident watchdog expiry
                if (tx_done) begin
`ifdef UART_ARB_TAG_EN
                    if (tag_phase_q) begin
                        tag_phase_d = 1'b0;
                        tx_data_d   = payload_q;
                        state_d     = S_START;
                    end else begin
                        state_d     = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
`ifdef UART_ARB_TAG_EN
                    tag_phase_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_q       <= GRANT_RST;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            active_q      <= (state_d != S_IDLE);
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

`ifdef UART_ARB_TAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload_q   <= 8'h00;
            tag_phase_q <= 1'b0;
        end else begin
            payload_q   <= payload_d;
            tag_phase_q <= tag_phase_d;
        end
    end
`endif

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table plus hand sequences, with a fast
// serial uart_tx model (4 clocks per bit) and a line decoder.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 50;
    localparam int BP          = 4;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [2:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic        model_en, f_busy, f_done;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    // uart_tx model: 8N1 frame, BP clocks per bit, tx_done pulse after the stop bit
    logic       m_busy, m_done, line;
    logic [9:0] m_shift;
    int         m_tick, m_bit;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_shift <= '1; m_tick <= 0; m_bit <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (model_en && tx_start) begin
                    m_busy <= 1'b1; m_shift <= {1'b1, tx_data, 1'b0}; m_tick <= 0; m_bit <= 0;
                end
            end else if (m_tick == BP - 1) begin
                m_tick <= 0;
                if (m_bit == 9) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_shift <= {1'b1, m_shift[9:1]}; m_bit <= m_bit + 1;
                end
            end else begin
                m_tick <= m_tick + 1;
            end
        end
    end

    assign line    = m_busy ? m_shift[0] : 1'b1;
    assign tx_busy = model_en ? m_busy : f_busy;
    assign tx_done = model_en ? m_done : f_done;

    // Line decoder: mid-bit sampling, byte stored once a valid stop bit is seen
    logic       rx_busy;
    int         rx_cnt, rx_n;
    logic [7:0] rx_sh;
    logic [7:0] rx_mem [64];
    int         rx_wr = 0;
    int         rd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_busy <= 1'b0; rx_cnt <= 0; rx_n <= 0; rx_sh <= '0;
        end else if (!rx_busy) begin
            if (!line) begin
                rx_busy <= 1'b1; rx_cnt <= BP + BP / 2 - 1; rx_n <= 0;
            end
        end else if (rx_cnt != 0) begin
            rx_cnt <= rx_cnt - 1;
        end else begin
            rx_cnt <= BP - 1;
            if (rx_n == 8) begin
                rx_busy <= 1'b0;
                if (line) begin
                    rx_mem[rx_wr % 64] <= rx_sh;
                    rx_wr <= rx_wr + 1;
                end
            end else begin
                rx_sh <= {line, rx_sh[7:1]};
                rx_n  <= rx_n + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (!active) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_bytes(input string nm, input int nb, input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("%s_rx_avail%0d", nm, k), 32'(rd != rx_wr), 1);
            chk($sformatf("%s_rx_byte%0d", nm, k), 32'(rx_mem[rd % 64]), 32'(k == 0 ? b0 : b1));
            rd++;
        end
        chk($sformatf("%s_rx_extra", nm), 32'(rx_wr - rd), 0);
        rd = rx_wr;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [2:0] id;
    } vec_t;
    vec_t vt [12];

    initial begin
        #1ms;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit         ok;
        int         n;
        logic [7:0] pay, first;

        vt[0]  = '{4'b1111, 3'd0};
        vt[1]  = '{4'b1111, 3'd1};
        vt[2]  = '{4'b1111, 3'd2};
        vt[3]  = '{4'b1111, 3'd3};
        vt[4]  = '{4'b1111, 3'd0};
        vt[5]  = '{4'b1010, 3'd1};
        vt[6]  = '{4'b1010, 3'd3};
        vt[7]  = '{4'b1010, 3'd1};
        vt[8]  = '{4'b0100, 3'd2};
        vt[9]  = '{4'b0101, 3'd0};
        vt[10] = '{4'b1001, 3'd3};
        vt[11] = '{4'b0110, 3'd1};

        rst = 1'b1; req_valid = '0; req_data = '0;
        model_en = 1'b1; f_busy = 1'b0; f_done = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 3);
        chk("rst_active", 32'(active), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);

        // Single request: one-cycle ready latency, then tx_start
        rst = 1'b0;
        req_data[7:0] = 8'h41; req_valid = 4'b0001;
        @(negedge clk);
        chk("b_req_ready", 32'(req_ready), 1);
        chk("b_grant_id", 32'(grant_id), 0);
        chk("b_tx_data", 32'(tx_data), 32'(TAG ? 8'h30 : 8'h41));
        chk("b_tx_start_early", 32'(tx_start), 0);
        chk("b_active", 32'(active), 1);
        req_valid = '0;
        @(negedge clk);
        chk("b_tx_start", 32'(tx_start), 1);
        chk("b_ready_pulse", 32'(req_ready), 0);
        wait_idle(300, ok);
        chk("b_idle", 32'(ok), 1);
        check_bytes("b", TAG ? 2 : 1, TAG ? 8'h30 : 8'h41, 8'h41);
        chk("b_timeout_err", 32'(timeout_err), 0);

        // Vector table from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd = rx_wr;
        req_data = 32'hA3A2A1A0;
        for (int r = 0; r < 12; r++) begin
            req_valid = vt[r].valid;
            pay   = 8'hA0 + 8'(vt[r].id);
            first = TAG ? (8'h30 + 8'(vt[r].id)) : pay;
            wait_ready(ok);
            chk($sformatf("v%0d_ready_seen", r), 32'(ok), 1);
            chk($sformatf("v%0d_req_ready", r), 32'(req_ready), 32'(1) << vt[r].id);
            chk($sformatf("v%0d_grant_id", r), 32'(grant_id), 32'(vt[r].id));
            chk($sformatf("v%0d_tx_data", r), 32'(tx_data), 32'(first));
            @(negedge clk);
            chk($sformatf("v%0d_tx_start", r), 32'(tx_start), 1);
            wait_idle(300, ok);
            chk($sformatf("v%0d_idle", r), 32'(ok), 1);
            check_bytes($sformatf("v%0d", r), TAG ? 2 : 1, first, pay);
        end
        req_valid = '0;

        // tx_busy holds off the grant; grant follows one cycle after release
        model_en = 1'b0; f_busy = 1'b1;
        req_valid = 4'b0100;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0 || tx_start) n++;
        end
        chk("c_no_grant_while_busy", 32'(n), 0);
        f_busy = 1'b0;
        @(negedge clk);
        chk("c_req_ready", 32'(req_ready), 4);
        chk("c_grant_id", 32'(grant_id), 2);
        req_valid = '0;
        @(negedge clk);
        chk("c_tx_start", 32'(tx_start), 1);
        f_done = 1'b1;
        wait_idle(20, ok);
        f_done = 1'b0;
        chk("c_idle", 32'(ok), 1);

        // Watchdog: no tx_done, error exactly TIMEOUT_CYC cycles after tx_start
        req_valid = 4'b0001;
        wait_ready(ok);
        chk("d_ready_seen", 32'(ok), 1);
        chk("d_grant_id", 32'(grant_id), 0);
        req_valid = '0;
        @(negedge clk);
        chk("d_tx_start", 32'(tx_start), 1);
        ok = 1'b0; n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (timeout_err) begin n = c; ok = 1'b1; break; end
        end
        chk("d_timeout_seen", 32'(ok), 1);
        chk("d_timeout_cycles", 32'(n), 32'(TIMEOUT_CYC));
        chk("d_active_after_abort", 32'(active), 0);
        req_valid = 4'b0010;
        wait_ready(ok);
        chk("d_next_ready_seen", 32'(ok), 1);
        chk("d_next_req_ready", 32'(req_ready), 2);
        req_valid = '0;
        @(negedge clk);
        chk("d_next_tx_start", 32'(tx_start), 1);
        f_done = 1'b1;
        wait_idle(20, ok);
        f_done = 1'b0;
        chk("d_next_idle", 32'(ok), 1);
        chk("d_err_sticky", 32'(timeout_err), 1);

        // Asynchronous reset in the middle of a frame
        model_en = 1'b1;
        req_valid = 4'b0100;
        wait_ready(ok);
        chk("f_ready_seen", 32'(ok), 1);
        chk("f_grant_id", 32'(grant_id), 2);
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("f_active_mid", 32'(active), 1);
        #2 rst = 1'b1;
        #1;
        chk("f_tx_start", 32'(tx_start), 0);
        chk("f_active", 32'(active), 0);
        chk("f_timeout_err", 32'(timeout_err), 0);
        chk("f_req_ready", 32'(req_ready), 0);
        chk("f_grant_id_rst", 32'(grant_id), 3);
        chk("f_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        rd = rx_wr;

        // tx_done on the watchdog's last cycle counts as done
        model_en = 1'b0;
        req_valid = 4'b0001;
        wait_ready(ok);
        chk("e_ready_seen", 32'(ok), 1);
        chk("e_grant_id", 32'(grant_id), 0);
        req_valid = '0;
        @(negedge clk);
        chk("e_tx_start", 32'(tx_start), 1);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        f_done = 1'b1;
        @(negedge clk);
        f_done = 1'b0;
        chk("e_no_timeout", 32'(timeout_err), 0);
        chk("e_active", 32'(active), 32'(TAG));
        f_done = 1'b1;
        wait_idle(20, ok);
        f_done = 1'b0;
        chk("e_idle", 32'(ok), 1);
        chk("e_no_timeout_end", 32'(timeout_err), 0);

`ifdef UART_ARB_TAG_EN
        // Tag then payload on the line, then reset during a payload frame
        model_en = 1'b1;
        req_data[23:16] = 8'h55;
        req_valid = 4'b0100;
        wait_ready(ok);
        chk("g_ready_seen", 32'(ok), 1);
        chk("g_tx_data_tag", 32'(tx_data), 32'h32);
        req_valid = '0;
        wait_idle(300, ok);
        chk("g_idle", 32'(ok), 1);
        check_bytes("g", 2, 8'h32, 8'h55);
        req_valid = 4'b0100;
        wait_ready(ok);
        chk("g2_ready_seen", 32'(ok), 1);
        req_valid = '0;
        ok = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (tx_start && rd != rx_wr) begin ok = 1'b1; break; end
        end
        chk("g2_payload_start", 32'(ok), 1);
        chk("g2_tx_data_payload", 32'(tx_data), 32'h55);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("g2_tx_start", 32'(tx_start), 0);
        chk("g2_active", 32'(active), 0);
        chk("g2_timeout_err", 32'(timeout_err), 0);
        check_bytes("g2", 1, 8'h32, 8'h00);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
